// File: rtl/signed_bcd_display_seq_if.sv
// ----------------------------------------------------------------------------
// signed_bcd_display_seq_if
// Bundles the control, value and display signals of signed_bcd_display_seq.
//   en         : keep refreshing channels (low = park after current STORE)
//   value      : CHANNELS packed signed WIDTH-bit inputs
//   seg        : CHANNELS*DIGITS active-low 7-segment codes (bit0=a..bit6=g)
//   neg / ovf  : per-channel sign and overflow flags
//   frame_done : one-cycle pulse after the last channel is refreshed
// master = value/enable source, slave = the display sequencer.
// ----------------------------------------------------------------------------
interface signed_bcd_display_seq_if #(
    parameter int WIDTH    = 6,
    parameter int DIGITS   = 2,
    parameter int CHANNELS = 3
);
    logic                           en;
    logic [CHANNELS*WIDTH-1:0]      value;
    logic [CHANNELS*DIGITS*7-1:0]   seg;
    logic [CHANNELS-1:0]            neg;
    logic [CHANNELS-1:0]            ovf;
    logic                           frame_done;

    modport master (output en, value, input seg, neg, ovf, frame_done);
    modport slave  (input en, value, output seg, neg, ovf, frame_done);
endinterface

// File: rtl/signed_bcd_display_seq.sv
// ----------------------------------------------------------------------------
// signed_bcd_display_seq
// Round-robin signed-to-7-segment display driver. One shared double-dabble
// engine converts each channel's magnitude in WIDTH shift cycles; results are
// registered per channel so displays stay stable between refreshes.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (blanks all displays)
//   bus   : signed_bcd_display_seq_if.slave (en, value, seg, neg, ovf,
//           frame_done)
// Optional build macro SIGNED_BCD_LEADING_ZERO_BLANK_EN: blank leading zero
// digits (ones digit always shown, overflow dashes unaffected).
// ----------------------------------------------------------------------------

// Per-digit encoder: BCD nibble to active-low segments with dash/blank forcing.
module signed_bcd_display_seq_digit (
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    input  logic       i_dash,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = 7'h7F;
        if (i_dash)       o_seg = 7'h3F;
        else if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = 7'h40;
                4'd1:    o_seg = 7'h79;
                4'd2:    o_seg = 7'h24;
                4'd3:    o_seg = 7'h30;
                4'd4:    o_seg = 7'h19;
                4'd5:    o_seg = 7'h12;
                4'd6:    o_seg = 7'h02;
                4'd7:    o_seg = 7'h78;
                4'd8:    o_seg = 7'h00;
                4'd9:    o_seg = 7'h10;
                default: o_seg = 7'h7F;
            endcase
        end
    end
endmodule

module signed_bcd_display_seq #(
    parameter int WIDTH    = 6,
    parameter int DIGITS   = 2,
    parameter int CHANNELS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    signed_bcd_display_seq_if.slave  bus
);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Smallest magnitude that no longer fits in DIGITS decimal digits.
    localparam logic [63:0] LIMIT = 64'(pow10(DIGITS));

    typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_STORE} state_t;

    state_t                               r_state, w_next;
    logic [IDX_W-1:0]                     r_idx;
    logic [CNT_W-1:0]                     r_cnt;
    logic [WIDTH-1:0]                     r_mag;
    logic [BCD_W-1:0]                     r_bcd;
    logic                                 r_sign;
    logic                                 r_big;
    logic [CHANNELS-1:0][DIGITS-1:0][6:0] r_seg;
    logic [CHANNELS-1:0]                  r_neg;
    logic [CHANNELS-1:0]                  r_ovf;
    logic                                 r_fd;

    logic [WIDTH-1:0]                     w_sel;
    logic [WIDTH-1:0]                     w_mag;
    logic                                 w_big;
    logic [BCD_W-1:0]                     w_adj;
    logic [DIGITS-1:0]                    w_blank;
    logic [DIGITS-1:0][6:0]               w_dseg;

    assign w_sel = bus.value[int'(r_idx)*WIDTH +: WIDTH];
    // Unsigned magnitude: the most negative input maps to 2^(WIDTH-1).
    assign w_mag = w_sel[WIDTH-1] ? (~w_sel + WIDTH'(1)) : w_sel;
    assign w_big = ({{(64-WIDTH){1'b0}}, w_mag} >= LIMIT);

    // Double-dabble correction applied before each shift.
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++)
            if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end

    always_comb begin
        w_blank = '0;
`ifdef SIGNED_BCD_LEADING_ZERO_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            // Walk down from the top digit; ones digit (d=0) is never blanked.
            for (int d = DIGITS - 1; d >= 1; d--) begin
                lead       = lead && (r_bcd[4*d +: 4] == 4'd0);
                w_blank[d] = lead;
            end
        end
`endif
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        signed_bcd_display_seq_digit u_dig (
            .i_bcd   (r_bcd[4*d +: 4]),
            .i_blank (w_blank[d]),
            .i_dash  (r_big),
            .o_seg   (w_dseg[d])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  if (bus.en) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_STORE;
            S_STORE: w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_cnt  <= '0;
            r_mag  <= '0;
            r_bcd  <= '0;
            r_sign <= 1'b0;
            r_big  <= 1'b0;
            r_seg  <= '1;
            r_neg  <= '0;
            r_ovf  <= '0;
            r_fd   <= 1'b0;
        end else begin
            r_fd <= 1'b0;
            case (r_state)
                S_LOAD: if (bus.en) begin
                    r_mag  <= w_mag;
                    r_sign <= w_sel[WIDTH-1];
                    r_big  <= w_big;
                    r_bcd  <= '0;
                    r_cnt  <= '0;
                end
                S_SHIFT: begin
                    {r_bcd, r_mag} <= {w_adj[BCD_W-2:0], r_mag, 1'b0};
                    r_cnt          <= r_cnt + CNT_W'(1);
                end
                S_STORE: begin
                    r_seg[r_idx] <= w_dseg;
                    r_neg[r_idx] <= r_sign;
                    r_ovf[r_idx] <= r_big;
                    if (r_idx == IDX_W'(CHANNELS - 1)) begin
                        r_idx <= '0;
                        r_fd  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.seg        = r_seg;
    assign bus.neg        = r_neg;
    assign bus.ovf        = r_ovf;
    assign bus.frame_done = r_fd;
endmodule

// File: tb/tb_signed_bcd_display_seq.sv
module tb_signed_bcd_display_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    signed_bcd_display_seq_if #(.WIDTH(6), .DIGITS(2), .CHANNELS(3)) i0 ();
    signed_bcd_display_seq_if #(.WIDTH(6), .DIGITS(1), .CHANNELS(3)) i1 ();

    signed_bcd_display_seq #(.WIDTH(6), .DIGITS(2), .CHANNELS(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(i0));
    signed_bcd_display_seq #(.WIDTH(6), .DIGITS(1), .CHANNELS(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(i1));

`ifdef SIGNED_BCD_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif
    localparam logic [41:0] BLANK = {42{1'b1}};
    localparam logic [13:0] BL2   = {14{1'b1}};

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0]  v0, v1, v2;
        logic [13:0] s0, s1, s2;
        logic [2:0]  neg;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_fd(input int which, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            seen = (which == 0) ? i0.frame_done : i1.frame_done;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: frame_done got timeout want pulse", name);
        end
    endtask

    vec_t tbl[5];
    int   fd_cycle;
    bit   early_bad;
    bit   changed;
    logic [41:0] snap_seg;
    logic [2:0]  snap_neg;

    initial begin
        tbl[0] = '{6'd0,      6'd7,      6'd13,     {LZ, 7'h40},    {LZ, 7'h78},    {7'h79, 7'h30}, 3'b000};
        tbl[1] = '{6'b100000, 6'b111111, 6'd31,     {7'h30, 7'h24}, {LZ, 7'h79},    {7'h30, 7'h79}, 3'b011};
        tbl[2] = '{6'd10,     6'b110110, 6'b100101, {7'h79, 7'h40}, {7'h79, 7'h40}, {7'h24, 7'h78}, 3'b110};
        tbl[3] = '{6'd19,     6'd28,     6'b111011, {7'h79, 7'h10}, {7'h24, 7'h00}, {LZ, 7'h12},    3'b100};
        tbl[4] = '{6'd20,     6'd9,      6'b110000, {7'h24, 7'h40}, {LZ, 7'h10},    {7'h79, 7'h02}, 3'b100};

        i0.en = 1'b0; i0.value = '0;
        i1.en = 1'b0; i1.value = '0;
        repeat (2) @(negedge clk);
        chk("reset_seg", i0.seg, BLANK);
        chk("reset_neg_ovf", {i0.neg, i0.ovf}, 6'b0);
        chk("reset_fd", i0.frame_done, 1'b0);
        chk("reset_seg_d1", i1.seg, {21{1'b1}});

        // Power-up frame: ch0 first at cycle 8, frame_done at cycle 24.
        i0.value = {6'd13, 6'd7, 6'd0};
        i0.en    = 1'b1;
        i1.value = {6'd9, 6'b101100, 6'd25};
        i1.en    = 1'b1;
        rst_n    = 1'b1;
        fd_cycle  = -1;
        early_bad = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            tick(1);
            if (i0.frame_done && fd_cycle < 0) fd_cycle = c;
            if (c < 8 && i0.seg !== BLANK) early_bad = 1'b1;
            if (c == 8) begin
                chk("c8_ch0", i0.seg[13:0], {LZ, 7'h40});
                chk("c8_ch12_blank", i0.seg[41:14], {BL2, BL2});
                chk("c8_neg", i0.neg, 3'b000);
            end
            if (c == 24) begin
                chk("c24_ch1", i0.seg[27:14], {LZ, 7'h78});
                chk("c24_ch2", i0.seg[41:28], {7'h79, 7'h30});
            end
        end
        chk("blank_before_c8", early_bad, 1'b0);
        chk("fd_first_cycle", fd_cycle, 24);

        for (int v = 0; v < 5; v++) begin
            i0.value = {tbl[v].v2, tbl[v].v1, tbl[v].v0};
            wait_fd(0, $sformatf("v%0d_fd_a", v));
            wait_fd(0, $sformatf("v%0d_fd_b", v));
            chk($sformatf("v%0d_ch0", v), i0.seg[13:0],  tbl[v].s0);
            chk($sformatf("v%0d_ch1", v), i0.seg[27:14], tbl[v].s1);
            chk($sformatf("v%0d_ch2", v), i0.seg[41:28], tbl[v].s2);
            chk($sformatf("v%0d_neg", v), i0.neg, tbl[v].neg);
            chk($sformatf("v%0d_ovf", v), i0.ovf, 3'b000);
            tick(1);
            chk($sformatf("v%0d_fd_width", v), i0.frame_done, 1'b0);
        end

        // Single-digit instance: overflow boundaries (25, -20, 10 vs 9).
        chk("d1_a_seg", i1.seg, {7'h10, 7'h3F, 7'h3F});
        chk("d1_a_ovf", i1.ovf, 3'b011);
        chk("d1_a_neg", i1.neg, 3'b010);
        i1.value = {6'd0, 6'b110110, 6'd9};
        wait_fd(1, "d1_fd_a");
        wait_fd(1, "d1_fd_b");
        chk("d1_b_seg", i1.seg, {7'h40, 7'h3F, 7'h10});
        chk("d1_b_ovf", i1.ovf, 3'b010);
        chk("d1_b_neg", i1.neg, 3'b010);

        // Value change during ch1 SHIFT only shows one frame later.
        i0.value = {6'd13, 6'd7, 6'd0};
        wait_fd(0, "mid_fd_a");
        wait_fd(0, "mid_fd_b");
        tick(10);
        i0.value[11:6] = 6'd20;
        wait_fd(0, "mid_fd_c");
        chk("mid_ch1_old", i0.seg[27:14], {LZ, 7'h78});
        chk("mid_ch0", i0.seg[13:0], {LZ, 7'h40});
        chk("mid_ch2", i0.seg[41:28], {7'h79, 7'h30});
        wait_fd(0, "mid_fd_d");
        chk("mid_ch1_new", i0.seg[27:14], {7'h24, 7'h40});
        chk("mid_ch02_held", {i0.seg[41:28], i0.seg[13:0]}, {7'h79, 7'h30, LZ, 7'h40});

        // en drop during ch1 SHIFT: ch1 STORE completes, then everything holds.
        i0.value[11:6]  = 6'b111101;
        i0.value[17:12] = 6'd31;
        tick(10);
        i0.en = 1'b0;
        tick(6);
        chk("en_ch1_stored", i0.seg[27:14], {LZ, 7'h30});
        chk("en_ch1_neg", i0.neg, 3'b010);
        snap_seg = i0.seg;
        snap_neg = i0.neg;
        changed  = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick(1);
            if (i0.seg !== snap_seg || i0.neg !== snap_neg || i0.frame_done) changed = 1'b1;
        end
        chk("en_hold_50", changed, 1'b0);
        i0.en = 1'b1;
        tick(7);
        chk("en_ch2_not_yet", i0.seg[41:28], {7'h79, 7'h30});
        chk("en_fd_not_yet", i0.frame_done, 1'b0);
        tick(1);
        chk("en_ch2_resume", i0.seg[41:28], {7'h30, 7'h79});
        chk("en_fd_resume", i0.frame_done, 1'b1);

        // Asynchronous reset in the middle of ch0 SHIFT.
        i0.value[5:0] = 6'd5;
        tick(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", i0.seg, BLANK);
        chk("arst_neg_ovf", {i0.neg, i0.ovf}, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(7);
        chk("arst_c7_blank", i0.seg, BLANK);
        tick(1);
        chk("arst_ch0", i0.seg[13:0], {LZ, 7'h12});
        chk("arst_ch12_blank", i0.seg[41:14], {BL2, BL2});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/signed_bcd_display_seq.md
Name: signed_bcd_display_seq

Overview:
- Parametrised, sequential successor to the combinational signed-to-7-segment display path.
- Round-robins over CHANNELS signed two's-complement inputs and converts each magnitude to decimal with an iterative shift-add-3 (double-dabble) engine.
- Drives DIGITS active-low 7-segment codes plus a sign flag per channel from registered outputs.
- Sits between the ALU operand/result registers and the board HEX displays; replaces per-channel divide/modulo logic with one shared converter.

Parameters:
- WIDTH, 6: bit width of each signed input value (>=2).
- DIGITS, 2: decimal digits displayed per channel (1..4).
- CHANNELS, 3: number of independent values displayed (>=1).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  high = keep refreshing; low = stop after the current channel's STORE.
- value  input  CHANNELS*WIDTH  packed signed inputs; channel k = value[k*WIDTH +: WIDTH].
- seg  output  CHANNELS*DIGITS*7  active-low segments; channel k digit d (d=0 is ones) at seg[(k*DIGITS+d)*7 +: 7], bit0=a … bit6=g.
- neg  output  CHANNELS  per-channel sign (1 = displayed value negative).
- ovf  output  CHANNELS  per-channel overflow: magnitude > 10^DIGITS-1.
- frame_done  output  1  one-cycle pulse when all channels have been refreshed.

Behaviour:
- Reset (async, rst_n=0):
  - All seg = 7'h7F (blank); neg=0, ovf=0, frame_done=0.
  - FSM enters LOAD; channel index = 0.
  - Reset asserted mid-conversion discards all partial state.
- FSM states:
  - LOAD:
    - If en=0, stay in LOAD and sample nothing.
    - Otherwise sample channel idx; mag = (msb ? ~v+1 : v), held as an unsigned WIDTH-bit value (the most negative input, e.g. -32, gives mag 32).
    - Latch sign; clear BCD accumulator (4*DIGITS bits); go to SHIFT.
  - SHIFT, exactly WIDTH cycles: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, mag} left by 1. Go to STORE after the WIDTH-th shift.
  - STORE, 1 cycle:
    - Register seg/neg/ovf for channel idx.
    - If idx = CHANNELS-1: idx wraps to 0 and frame_done is registered high for the next cycle. Otherwise idx+1.
    - Go to LOAD.
- Latency:
  - One channel takes WIDTH+2 cycles.
  - Outputs for channel idx change on the clock edge that ends STORE.
  - Frame period = CHANNELS*(WIDTH+2) cycles (24 at defaults).
  - frame_done is high for exactly one cycle, coincident with the last channel's new outputs.
- Input sampling: value is sampled only in LOAD. Changes during SHIFT/STORE take effect on that channel's next visit. Other channels' outputs are held unchanged.
- Overflow:
  - Compare mag >= 10^DIGITS (constant, computed at elaboration).
  - If true: ovf[k]=1, all digits of channel k = 7'h3F (dash, g only), neg[k] still reflects the sign.
- Digit encoding, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - BCD nibbles >9 cannot occur; default blank 7F.
- Zero: input 0 gives neg=0 and all digits "0" (subject to the optional feature).
- en deasserted during SHIFT: the conversion completes, STORE executes, then the FSM holds in LOAD. On reassertion it resumes at the next idx, not at 0.
- Simultaneous en fall and STORE on the last channel: frame_done still pulses.

Optional Feature:
- Macro: SIGNED_BCD_LEADING_ZERO_BLANK_EN.
- Defined: every digit above the most significant non-zero digit shows blank (7'h7F). The ones digit is never blanked, so 5 gives blank,"5" and 0 gives blank,"0". Overflow dashes are unaffected.
- Undefined: all digits shown, including leading zeros (5 gives "0","5").

Test Plan:
- Reset then en=1, value={ch2=6'd13, ch1=6'd7, ch0=6'd0}: outputs stay blank and frame_done=0 until cycle 8 → ch0 seg={40,40}, neg[0]=0; frame_done pulses at cycle 24 with ch1={40,78}, ch2={79,30}.
- ch0 = 6'b100000 (-32) → neg[0]=1, seg digits {30,24} ("32"), ovf[0]=0. ch0 = 6'b111111 (-1) → neg=1, "01".
- Override DIGITS=1, ch0=6'd25 → ovf[0]=1, seg=3F, neg=0. ch0=6'd9 → ovf=0, seg=10.
- Change ch1 from 7 to 20 during ch1 SHIFT → ch1 still shows "07" this frame and shows "20" ({24,40}) one frame later; ch0/ch2 outputs are not disturbed.
- en=0 mid-SHIFT on ch1 → ch1 STORE completes, then no output changes for 50 cycles. en=1 → ch2 updates WIDTH+2 cycles later. frame_done timing shifts accordingly.
- Assert rst_n=0 asynchronously mid-SHIFT → all seg=7F, neg=ovf=0 immediately without a clock edge. After release, conversion restarts at ch0. With SIGNED_BCD_LEADING_ZERO_BLANK_EN defined, ch0=6'd5 → {7F,12}.
